// File: rtl/calc_stack_pkg.sv
// ============================================================================
// calc_pkg : opcode encoding shared by calc_stack and its bus interface
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  localparam int STACK_OP_W = 3;

  typedef enum logic [STACK_OP_W-1:0] {
    OP_NOP    = 3'b000,
    OP_PUSH   = 3'b001,
    OP_POP    = 3'b010,
    OP_WRITE  = 3'b011,
    OP_SWAP   = 3'b100,
    OP_DUP    = 3'b101,
    OP_REDUCE = 3'b110,
    OP_RSVD   = 3'b111
  } stack_op_t;

endpackage

`default_nettype wire

// File: rtl/calc_stack_if.sv
// ============================================================================
// calc_stack_if : opcode/operand bus and stack status outputs for calc_stack
// Optional clear signal present only with CALC_STACK_CLEAR_EN.
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

interface calc_stack_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  import calc_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  stack_op_t        op;
  logic [WIDTH-1:0] value;
`ifdef CALC_STACK_CLEAR_EN
  logic             clear;
`endif
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             error;

  modport master (
    output op, value,
`ifdef CALC_STACK_CLEAR_EN
    output clear,
`endif
    input  top, next, count, full, empty, error
  );

  modport slave (
    input  op, value,
`ifdef CALC_STACK_CLEAR_EN
    input  clear,
`endif
    output top, next, count, full, empty, error
  );

endinterface

`default_nettype wire

// File: rtl/calc_stack.sv
// ============================================================================
// calc_stack : parametrised RPN operand stack with encoded ops and error flag
// Define CALC_STACK_CLEAR_EN to enable the synchronous clear input.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module calc_stack
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  calc_stack_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             error_q, error_d;

  logic [CW-1:0]    n_m1, n_m2;
  logic             has1, has2, not_full, legal;
  logic [WIDTH-1:0] top_val, next_val;

  assign n_m1     = count_q - CW'(1);
  assign n_m2     = count_q - CW'(2);
  assign has1     = (count_q != '0);
  assign has2     = (count_q >= CW'(2));
  assign not_full = (count_q != CW'(DEPTH));

  always_comb begin
    top_val  = '0;
    next_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (has1 && (CW'(i) == n_m1)) top_val  = entry_q[i];
      if (has2 && (CW'(i) == n_m2)) next_val = entry_q[i];
    end
  end

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    error_d = error_q;
    legal   = 1'b0;

    case (bus.op)
      OP_PUSH:   legal = not_full;
      OP_POP:    legal = has1;
      OP_WRITE:  legal = has1;
      OP_SWAP:   legal = has2;
      OP_DUP:    legal = has1 && not_full;
      OP_REDUCE: legal = has2;
      default:   legal = 1'b0;
    endcase

    // NOP leaves the flag alone so it keeps describing the last real op
    if (bus.op != OP_NOP) error_d = ~legal;

    if (legal) begin
      for (int i = 0; i < DEPTH; i++) begin
        case (bus.op)
          OP_PUSH:   if (CW'(i) == count_q) entry_d[i] = bus.value;
          OP_POP:    if (CW'(i) == n_m1)    entry_d[i] = '0;
          OP_WRITE:  if (CW'(i) == n_m1)    entry_d[i] = bus.value;
          OP_SWAP: begin
            if (CW'(i) == n_m1) entry_d[i] = next_val;
            if (CW'(i) == n_m2) entry_d[i] = top_val;
          end
          OP_DUP:    if (CW'(i) == count_q) entry_d[i] = top_val;
          OP_REDUCE: begin
            if (CW'(i) == n_m2) entry_d[i] = bus.value;
            if (CW'(i) == n_m1) entry_d[i] = '0;
          end
          default: ;
        endcase
      end

      case (bus.op)
        OP_PUSH, OP_DUP:   count_d = count_q + CW'(1);
        OP_POP, OP_REDUCE: count_d = n_m1;
        default: ;
      endcase
    end

`ifdef CALC_STACK_CLEAR_EN
    if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
      count_d = '0;
      error_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign bus.top   = top_val;
  assign bus.next  = next_val;
  assign bus.count = count_q;
  assign bus.full  = ~not_full;
  assign bus.empty = ~has1;
  assign bus.error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_stack.sv
// ============================================================================
// tb_calc_stack : directed + random scoreboard bench for calc_stack
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_calc_stack;
  import calc_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [31:0] top;
    logic [31:0] next;
    logic [31:0] count;
    logic        full;
    logic        empty;
    logic        error;
  } exp_t;

  logic clock;
  logic reset_n;

  calc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  calc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mstk [$];
  logic        merr;
  exp_t        sb [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue with element 0 at the bottom of the stack
  task automatic model_apply(input stack_op_t op, input logic [31:0] v);
    int n;
    bit ok;
    logic [31:0] tmp;
    n  = mstk.size();
    ok = 1'b0;
    case (op)
      OP_PUSH:   ok = (n < DEPTH);
      OP_POP:    ok = (n >= 1);
      OP_WRITE:  ok = (n >= 1);
      OP_SWAP:   ok = (n >= 2);
      OP_DUP:    ok = (n >= 1) && (n < DEPTH);
      OP_REDUCE: ok = (n >= 2);
      default:   ok = 1'b0;
    endcase
    if (op != OP_NOP) merr = !ok;
    if (ok) begin
      case (op)
        OP_PUSH:   mstk.push_back(v);
        OP_POP:    void'(mstk.pop_back());
        OP_WRITE:  mstk[n-1] = v;
        OP_SWAP: begin
          tmp = mstk[n-1]; mstk[n-1] = mstk[n-2]; mstk[n-2] = tmp;
        end
        OP_DUP:    mstk.push_back(mstk[n-1]);
        OP_REDUCE: begin
          void'(mstk.pop_back());
          mstk[n-2] = v;
        end
        default: ;
      endcase
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    int n;
    n       = mstk.size();
    e.top   = (n >= 1) ? mstk[n-1] : 32'd0;
    e.next  = (n >= 2) ? mstk[n-2] : 32'd0;
    e.count = 32'(n);
    e.full  = (n == DEPTH);
    e.empty = (n == 0);
    e.error = merr;
    return e;
  endfunction

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("top",   bus.top,          e.top);
    check("next",  bus.next,         e.next);
    check("count", 32'(bus.count),   e.count);
    check("full",  32'(bus.full),    32'(e.full));
    check("empty", 32'(bus.empty),   32'(e.empty));
    check("error", 32'(bus.error),   32'(e.error));
  endtask

  task automatic do_op(input stack_op_t op, input logic [31:0] v);
    @(negedge clock);
    bus.op    = op;
    bus.value = v;
    model_apply(op, v);
    sb.push_back(model_exp());
    @(posedge clock);
    #1;
    check_sb();
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.op    = OP_NOP;
    bus.value = '0;
`ifdef CALC_STACK_CLEAR_EN
    bus.clear = 1'b0;
`endif
    merr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    sb.push_back(model_exp());
    check_sb();
    @(negedge clock);
    reset_n = 1'b1;

    // push three and inspect
    do_op(OP_PUSH, 32'd1);
    do_op(OP_PUSH, 32'd2);
    do_op(OP_PUSH, 32'd3);
    check("t1_top", bus.top, 32'd3);
    check("t1_next", bus.next, 32'd2);
    check("t1_count", 32'(bus.count), 32'd3);
    check("t1_error", 32'(bus.error), 32'd0);

    do_op(OP_SWAP, 32'hDEAD);
    check("t2_swap_top", bus.top, 32'd2);
    check("t2_swap_next", bus.next, 32'd3);
    do_op(OP_WRITE, 32'd7);
    check("t2_write_top", bus.top, 32'd7);
    check("t2_write_next", bus.next, 32'd3);

    do_op(OP_REDUCE, 32'd10);
    check("t3_reduce_top", bus.top, 32'd10);
    check("t3_reduce_next", bus.next, 32'd1);
    check("t3_reduce_count", 32'(bus.count), 32'd2);
    do_op(OP_DUP, 32'd0);
    check("t3_dup_top", bus.top, 32'd10);
    check("t3_dup_next", bus.next, 32'd10);
    check("t3_dup_count", 32'(bus.count), 32'd3);

    // drain, then underflow
    repeat (3) do_op(OP_POP, 32'd0);
    do_op(OP_POP, 32'd0);
    check("t4_pop_err", 32'(bus.error), 32'd1);
    check("t4_pop_count", 32'(bus.count), 32'd0);
    do_op(OP_NOP, 32'd0);
    check("t4_nop_err", 32'(bus.error), 32'd1);
    do_op(OP_WRITE, 32'd9);
    do_op(OP_RSVD, 32'd9);
    check("t4_rsvd_err", 32'(bus.error), 32'd1);
    do_op(OP_PUSH, 32'd5);
    check("t4_push_err", 32'(bus.error), 32'd0);
    check("t4_push_top", bus.top, 32'd5);

    // fill to DEPTH, then overflow
    for (int i = 1; i < DEPTH; i++) do_op(OP_PUSH, 32'(100 + i));
    check("t5_full", 32'(bus.full), 32'd1);
    do_op(OP_PUSH, 32'd99);
    check("t5_ovf_err", 32'(bus.error), 32'd1);
    check("t5_ovf_count", 32'(bus.count), 32'(DEPTH));
    check("t5_ovf_top", bus.top, 32'(100 + DEPTH - 1));
    do_op(OP_DUP, 32'd0);
    check("t5_dup_full_err", 32'(bus.error), 32'd1);
    for (int i = 1; i < DEPTH; i++) do_op(OP_POP, 32'd0);
    do_op(OP_SWAP, 32'd0);
    check("t5_swap1_err", 32'(bus.error), 32'd1);
    do_op(OP_REDUCE, 32'd77);
    check("t5_reduce1_err", 32'(bus.error), 32'd1);
    check("t5_reduce1_top", bus.top, 32'd5);
    check("t5_reduce1_count", 32'(bus.count), 32'd1);

    // random mix against the model
    for (int i = 0; i < 60; i++)
      do_op(stack_op_t'($urandom_range(0, 7)), $urandom());

    // asynchronous reset between edges
    do_op(OP_POP, 32'd0);
    while (mstk.size() > 0) do_op(OP_POP, 32'd0);
    do_op(OP_PUSH, 32'd11);
    do_op(OP_PUSH, 32'd12);
    do_op(OP_PUSH, 32'd13);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(bus.count), 32'd0);
    check("t6_rst_top", bus.top, 32'd0);
    check("t6_rst_empty", 32'(bus.empty), 32'd1);
    mstk.delete();
    merr = 1'b0;
    bus.op = OP_NOP;
    @(negedge clock);
    reset_n = 1'b1;
    do_op(OP_NOP, 32'd0);

`ifdef CALC_STACK_CLEAR_EN
    do_op(OP_PUSH, 32'd21);
    do_op(OP_PUSH, 32'd22);
    do_op(OP_POP, 32'd0);
    do_op(OP_POP, 32'd0);
    do_op(OP_POP, 32'd0);
    do_op(OP_PUSH, 32'd23);
    @(negedge clock);
    bus.clear = 1'b1;
    bus.op    = OP_PUSH;
    bus.value = 32'd42;
    mstk.delete();
    merr = 1'b0;
    sb.push_back(model_exp());
    @(posedge clock);
    #1;
    check_sb();
    check("t6_clear_count", 32'(bus.count), 32'd0);
    @(negedge clock);
    bus.clear = 1'b0;
    bus.op    = OP_NOP;
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
